// File: rtl/fsk_bit_slicer_pkg.sv
// Shared types and helpers for the FSK bit slicer: FSM states, decision codes,
// bit-period arithmetic and the tone-dominance decision.
package fsk_bit_slicer_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEC_W  = 40;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_MEASURE = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_DECIDE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    DEC_ZERO       = 2'd0,
    DEC_ONE        = 2'd1,
    DEC_AMBIGUOUS  = 2'd2,
    DEC_NO_CARRIER = 2'd3
  } decision_e;

  function automatic int unsigned calc_bit_ticks(input int unsigned clock_hz,
                                                 input int unsigned bit_rate);
    return clock_hz / bit_rate;
  endfunction

  // CLEAR, SETTLE and DECIDE each take one cycle of the bit period.
  function automatic int unsigned calc_measure_ticks(input int unsigned clock_hz,
                                                     input int unsigned bit_rate);
    return calc_bit_ticks(clock_hz, bit_rate) - 3;
  endfunction

  // 40-bit products keep 32-bit counts times percentages from overflowing.
  function automatic decision_e decide(input logic [DATA_W-1:0] f1,
                                       input logic [DATA_W-1:0] f2,
                                       input int unsigned       measure,
                                       input int unsigned       margin_pct,
                                       input int unsigned       cover_pct);
    logic [DEC_W-1:0] a;
    logic [DEC_W-1:0] b;
    logic [DEC_W-1:0] total;
    logic [DEC_W-1:0] floor_v;
    a       = DEC_W'(f1);
    b       = DEC_W'(f2);
    total   = (a + b) * DEC_W'(100);
    floor_v = DEC_W'(measure) * DEC_W'(cover_pct);
    if (total < floor_v) begin
      return DEC_NO_CARRIER;
    end
    if (b * DEC_W'(100) >= a * DEC_W'(100 + margin_pct)) begin
      return DEC_ONE;
    end
    if (a * DEC_W'(100) >= b * DEC_W'(100 + margin_pct)) begin
      return DEC_ZERO;
    end
    return DEC_AMBIGUOUS;
  endfunction

endpackage

// File: rtl/fsk_bit_slicer_word_assembler.sv
// Packs decided bits LSB-first into words with a sticky per-word error flag;
// a flush drops any partial word.
module fsk_bit_slicer_word_assembler
  import fsk_bit_slicer_pkg::*;
#(
  parameter int unsigned WORD_BITS = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              bit_i,
  input  logic              bit_valid_i,
  input  logic              bit_error_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] word_data_o,
  output logic              word_valid_o,
  output logic              word_error_o
);

  localparam int unsigned CNT_W = $clog2(WORD_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);

  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] acc_q;
  logic              sticky_q;
  logic [DATA_W-1:0] word_data_q;
  logic              word_valid_q;
  logic              word_error_q;
  logic [DATA_W-1:0] merged_c;

  assign merged_c = acc_q | (DATA_W'(bit_i) << bit_cnt_q);

  // A completing bit wins over a same-cycle flush: the word is whole, not partial.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_q    <= '0;
      acc_q        <= '0;
      sticky_q     <= 1'b0;
      word_data_q  <= '0;
      word_valid_q <= 1'b0;
      word_error_q <= 1'b0;
    end else begin
      word_valid_q <= 1'b0;
      if (bit_valid_i && (bit_cnt_q == LAST_BIT)) begin
        word_data_q  <= merged_c;
        word_valid_q <= 1'b1;
        word_error_q <= sticky_q | bit_error_i;
        acc_q        <= '0;
        sticky_q     <= 1'b0;
        bit_cnt_q    <= '0;
      end else if (flush_i) begin
        acc_q     <= '0;
        sticky_q  <= 1'b0;
        bit_cnt_q <= '0;
      end else if (bit_valid_i) begin
        acc_q     <= merged_c;
        sticky_q  <= sticky_q | bit_error_i;
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      end
    end
  end

  assign word_data_o  = word_data_q;
  assign word_valid_o = word_valid_q;
  assign word_error_o = word_error_q;

endmodule

// File: rtl/fsk_bit_slicer.sv
// Controls the two-tone analyzer over fixed bit periods, decides one FSK bit per
// period from the two tick counts, and hands bits to the word assembler.
module fsk_bit_slicer
  import fsk_bit_slicer_pkg::*;
#(
  parameter int unsigned CLOCK         = 50000000,
  parameter int unsigned BIT_RATE      = 10000,
  parameter int unsigned MARGIN_PCT    = 25,
  parameter int unsigned MIN_COVER_PCT = 50,
  parameter int unsigned WORD_BITS     = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              run,
  input  logic [DATA_W-1:0] f1_value,
  input  logic [DATA_W-1:0] f2_value,
  output logic              analyzer_enable,
  output logic              analyzer_clear,
  output logic              bit_value,
  output logic              bit_valid,
  output logic              bit_error,
  output logic [DATA_W-1:0] word_data,
  output logic              word_valid,
  output logic              word_error,
  output logic              busy
);

  localparam int unsigned BIT_TICKS     = calc_bit_ticks(CLOCK, BIT_RATE);
  localparam int unsigned MEASURE_TICKS = calc_measure_ticks(CLOCK, BIT_RATE);
  localparam int unsigned TICK_W        = $clog2(BIT_TICKS);
  localparam logic [TICK_W-1:0] MEASURE_LAST = TICK_W'(MEASURE_TICKS - 1);

  state_e            state_q;
  logic [TICK_W-1:0] tick_q;
  logic              enable_q;
  logic              clear_q;
  logic              bit_value_q;
  logic              bit_valid_q;
  logic              bit_error_q;
  logic              busy_q;

  decision_e dec_c;
  logic      dec_bit_c;
  logic      dec_err_c;
  logic      decide_c;
  logic      flush_c;

  assign dec_c     = decide(f1_value, f2_value, MEASURE_TICKS, MARGIN_PCT, MIN_COVER_PCT);
  assign dec_bit_c = (dec_c == DEC_ONE);
  assign dec_err_c = (dec_c == DEC_AMBIGUOUS) || (dec_c == DEC_NO_CARRIER);
  assign decide_c  = (state_q == ST_DECIDE);
  assign flush_c   = decide_c && !run;

  // Outputs change on the same edge as the state, so enable spans exactly MEASURE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      enable_q    <= 1'b0;
      clear_q     <= 1'b1;
      bit_value_q <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_error_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      bit_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          enable_q <= 1'b0;
          clear_q  <= 1'b1;
          if (run) begin
            state_q <= ST_CLEAR;
            busy_q  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          state_q  <= ST_MEASURE;
          tick_q   <= '0;
          enable_q <= 1'b1;
          clear_q  <= 1'b0;
        end
        ST_MEASURE: begin
          if (tick_q == MEASURE_LAST) begin
            state_q  <= ST_SETTLE;
            enable_q <= 1'b0;
          end else begin
            tick_q <= tick_q + TICK_W'(1);
          end
        end
        ST_SETTLE: begin
          state_q <= ST_DECIDE;
        end
        ST_DECIDE: begin
          bit_valid_q <= 1'b1;
          bit_value_q <= dec_bit_c;
          bit_error_q <= dec_err_c;
          clear_q     <= 1'b1;
          if (run) begin
            state_q <= ST_CLEAR;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          enable_q <= 1'b0;
          clear_q  <= 1'b1;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  fsk_bit_slicer_word_assembler #(
    .WORD_BITS(WORD_BITS)
  ) u_word_assembler (
    .clock        (clock),
    .reset_n      (reset_n),
    .bit_i        (dec_bit_c),
    .bit_valid_i  (decide_c),
    .bit_error_i  (dec_err_c),
    .flush_i      (flush_c),
    .word_data_o  (word_data),
    .word_valid_o (word_valid),
    .word_error_o (word_error)
  );

  assign analyzer_enable = enable_q;
  assign analyzer_clear  = clear_q;
  assign bit_value       = bit_value_q;
  assign bit_valid       = bit_valid_q;
  assign bit_error       = bit_error_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_fsk_bit_slicer.sv
// Directed bench for fsk_bit_slicer with a short bit period (20 cycles, 17 measure).
module tb_fsk_bit_slicer;

  localparam int unsigned CLK_HZ    = 1000000;
  localparam int unsigned RATE      = 50000;
  localparam int unsigned BIT_T     = 20;
  localparam int unsigned MEAS_T    = 17;

  logic        clock;
  logic        reset_n;
  logic        run;
  logic [31:0] f1_value;
  logic [31:0] f2_value;
  logic        analyzer_enable;
  logic        analyzer_clear;
  logic        bit_value;
  logic        bit_valid;
  logic        bit_error;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_error;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  fsk_bit_slicer #(
    .CLOCK(CLK_HZ), .BIT_RATE(RATE), .MARGIN_PCT(25), .MIN_COVER_PCT(50), .WORD_BITS(8)
  ) dut (
    .clock(clock), .reset_n(reset_n), .run(run),
    .f1_value(f1_value), .f2_value(f2_value),
    .analyzer_enable(analyzer_enable), .analyzer_clear(analyzer_clear),
    .bit_value(bit_value), .bit_valid(bit_valid), .bit_error(bit_error),
    .word_data(word_data), .word_valid(word_valid), .word_error(word_error),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Waits (bounded) for the next bit_valid, sampling on falling edges.
  task automatic wait_bit(output logic got, output int cycles, output int en_cycles,
                          output logic wv_seen);
    got = 1'b0; cycles = 0; en_cycles = 0; wv_seen = 1'b0;
    while (!got && cycles < 4 * BIT_T) begin
      @(negedge clock);
      cycles++;
      if (analyzer_enable) en_cycles++;
      if (word_valid) wv_seen = 1'b1;
      if (bit_valid) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; run = 1'b0; f1_value = '0; f2_value = '0;
    repeat (3) @(negedge clock);
    n_checks++; if (analyzer_clear !== 1'b1) begin n_fail++; $display("FAIL rst_clear: got %b expected 1", analyzer_clear); end
    n_checks++; if (analyzer_enable !== 1'b0) begin n_fail++; $display("FAIL rst_enable: got %b expected 0", analyzer_enable); end
    n_checks++; if ({bit_value, bit_valid, bit_error} !== 3'b000) begin n_fail++; $display("FAIL rst_bit: got %b expected 000", {bit_value, bit_valid, bit_error}); end
    n_checks++; if ({word_valid, word_error, busy} !== 3'b000) begin n_fail++; $display("FAIL rst_word_busy: got %b expected 000", {word_valid, word_error, busy}); end
    n_checks++; if (word_data !== 32'h0) begin n_fail++; $display("FAIL rst_word_data: got %h expected 0", word_data); end
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
    n_checks++; if ({analyzer_clear, analyzer_enable} !== 2'b10) begin n_fail++; $display("FAIL idle_ctrl: got %b expected 10", {analyzer_clear, analyzer_enable}); end
  endtask

  task automatic test_tone2();
    logic got, wv; int cyc, en;
    f1_value = 0; f2_value = 16; run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_bit(got, cyc, en, wv);
      n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL tone2_timeout bit %0d: got none expected bit_valid", i); end
      n_checks++; if ({bit_value, bit_error} !== 2'b10) begin n_fail++; $display("FAIL tone2_bit %0d: got %b expected 10", i, {bit_value, bit_error}); end
      n_checks++; if (word_valid !== (i == 7)) begin n_fail++; $display("FAIL tone2_wvalid %0d: got %b expected %b", i, word_valid, (i == 7)); end
      if (i > 0) begin
        n_checks++; if (cyc != BIT_T) begin n_fail++; $display("FAIL tone2_period %0d: got %0d expected %0d", i, cyc, BIT_T); end
      end
    end
    n_checks++; if (word_data !== 32'hFF) begin n_fail++; $display("FAIL tone2_word: got %h expected ff", word_data); end
    n_checks++; if (word_error !== 1'b0) begin n_fail++; $display("FAIL tone2_werr: got %b expected 0", word_error); end
  endtask

  task automatic test_alternate();
    logic got, wv; int cyc, en;
    for (int i = 0; i < 8; i++) begin
      f1_value = (i % 2 == 0) ? 32'd16 : 32'd0;
      f2_value = (i % 2 == 0) ? 32'd0 : 32'd16;
      wait_bit(got, cyc, en, wv);
      n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL alt_timeout bit %0d: got none expected bit_valid", i); end
      n_checks++; if (bit_value !== 1'(i % 2)) begin n_fail++; $display("FAIL alt_bit %0d: got %b expected %b", i, bit_value, 1'(i % 2)); end
      n_checks++; if (en != MEAS_T) begin n_fail++; $display("FAIL alt_enable_len %0d: got %0d expected %0d", i, en, MEAS_T); end
    end
    n_checks++; if ({word_valid, word_error} !== 2'b10) begin n_fail++; $display("FAIL alt_wflags: got %b expected 10", {word_valid, word_error}); end
    n_checks++; if (word_data !== 32'hAA) begin n_fail++; $display("FAIL alt_word: got %h expected aa", word_data); end
  endtask

  // Margin and coverage boundaries: cover floor 850 -> f1+f2 >= 9; margin 125%.
  task automatic test_ambiguous();
    logic got, wv; int cyc, en;
    int unsigned f1v [8] = '{8, 4, 8, 0, 10, 0, 0, 16};
    int unsigned f2v [8] = '{9, 4, 10, 9, 8, 8, 16, 0};
    logic [7:0] exp_val = 8'b0100_1100;
    logic [7:0] exp_err = 8'b0010_0011;
    for (int i = 0; i < 8; i++) begin
      f1_value = f1v[i]; f2_value = f2v[i];
      wait_bit(got, cyc, en, wv);
      n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL amb_timeout bit %0d: got none expected bit_valid", i); end
      n_checks++; if ({bit_value, bit_error} !== {exp_val[i], exp_err[i]}) begin n_fail++; $display("FAIL amb_bit %0d: got %b expected %b", i, {bit_value, bit_error}, {exp_val[i], exp_err[i]}); end
    end
    n_checks++; if (word_data !== 32'h4C) begin n_fail++; $display("FAIL amb_word: got %h expected 4c", word_data); end
    n_checks++; if ({word_valid, word_error} !== 2'b11) begin n_fail++; $display("FAIL amb_wflags: got %b expected 11", {word_valid, word_error}); end
  endtask

  task automatic test_stop_mid_word();
    logic got, wv, wv_any; int cyc, en;
    wv_any = 1'b0;
    for (int i = 0; i < 4; i++) begin
      f1_value = (i == 1) ? 32'd8 : 32'd0;
      f2_value = (i == 1) ? 32'd9 : 32'd16;
      if (i == 3) begin
        repeat (5) @(negedge clock);
        run = 1'b0;
      end
      wait_bit(got, cyc, en, wv);
      wv_any = wv_any | wv;
      n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL stop_timeout bit %0d: got none expected bit_valid", i); end
    end
    n_checks++; if ({bit_value, bit_error} !== 2'b10) begin n_fail++; $display("FAIL stop_last_bit: got %b expected 10", {bit_value, bit_error}); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_busy: got %b expected 0", busy); end
    repeat (BIT_T) begin
      @(negedge clock);
      wv_any = wv_any | word_valid;
    end
    n_checks++; if (wv_any !== 1'b0) begin n_fail++; $display("FAIL stop_no_word: got %b expected 0", wv_any); end
    n_checks++; if ({busy, analyzer_clear, analyzer_enable} !== 3'b010) begin n_fail++; $display("FAIL stop_idle: got %b expected 010", {busy, analyzer_clear, analyzer_enable}); end
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      f1_value = (i == 7) ? 32'd0 : 32'd16;
      f2_value = (i == 7) ? 32'd16 : 32'd0;
      wait_bit(got, cyc, en, wv);
      n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL restart_timeout bit %0d: got none expected bit_valid", i); end
      n_checks++; if (word_valid !== (i == 7)) begin n_fail++; $display("FAIL restart_wvalid %0d: got %b expected %b", i, word_valid, (i == 7)); end
    end
    n_checks++; if (word_data !== 32'h80) begin n_fail++; $display("FAIL restart_word: got %h expected 80", word_data); end
    n_checks++; if (word_error !== 1'b0) begin n_fail++; $display("FAIL restart_werr: got %b expected 0", word_error); end
  endtask

  task automatic test_reset_mid_measure();
    logic got, wv; int cyc, en;
    f1_value = 0; f2_value = 16;
    wait_bit(got, cyc, en, wv);
    repeat (6) @(negedge clock);
    n_checks++; if (analyzer_enable !== 1'b1) begin n_fail++; $display("FAIL mid_enable: got %b expected 1", analyzer_enable); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if ({analyzer_enable, analyzer_clear, busy} !== 3'b010) begin n_fail++; $display("FAIL async_rst: got %b expected 010", {analyzer_enable, analyzer_clear, busy}); end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      f1_value = (i % 2 == 0) ? 32'd0 : 32'd16;
      f2_value = (i % 2 == 0) ? 32'd16 : 32'd0;
      wait_bit(got, cyc, en, wv);
      n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL rstmid_timeout bit %0d: got none expected bit_valid", i); end
      n_checks++; if (word_valid !== (i == 7)) begin n_fail++; $display("FAIL rstmid_wvalid %0d: got %b expected %b", i, word_valid, (i == 7)); end
    end
    n_checks++; if (word_data !== 32'h55) begin n_fail++; $display("FAIL rstmid_word: got %h expected 55", word_data); end
    run = 1'b0;
    repeat (2 * BIT_T) @(negedge clock);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL final_idle: got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_tone2();
    test_alternate();
    test_ambiguous();
    test_stop_mid_word();
    test_reset_mid_measure();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
